// File: rtl/fk_pkg.sv
// Shared definitions for the forward-kinematics command path.
// Holds the joint angle grid (index 0..8 -> degrees), the default FK
// pipeline latency, the pose-sequencer state type and the grid-index type,
// plus a helper that moves one grid index a single step toward a target.
package fk_pkg;

  localparam int GRID_N             = 9;
  localparam int FK_LATENCY_DEFAULT = 3;

  // Supported table angles in degrees, one constant per grid index.
  localparam logic signed [15:0] DEG_0 = 16'sd0;
  localparam logic signed [15:0] DEG_1 = 16'sd30;
  localparam logic signed [15:0] DEG_2 = 16'sd45;
  localparam logic signed [15:0] DEG_3 = 16'sd60;
  localparam logic signed [15:0] DEG_4 = 16'sd90;
  localparam logic signed [15:0] DEG_5 = 16'sd120;
  localparam logic signed [15:0] DEG_6 = 16'sd135;
  localparam logic signed [15:0] DEG_7 = 16'sd150;
  localparam logic signed [15:0] DEG_8 = 16'sd180;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_DWELL  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  typedef logic [3:0] grid_idx_t;

  // One grid step of cur toward tgt: +1, -1 or hold.
  function automatic grid_idx_t step_toward(input grid_idx_t cur, input grid_idx_t tgt);
    if (cur < tgt) begin
      return cur + 4'd1;
    end else if (cur > tgt) begin
      return cur - 4'd1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/fk_angle_grid_lut.sv
// Combinational grid-index to degree lookup for one joint.
// Ports:
//   idx - grid index (legal 0..8)
//   deg - signed angle in degrees; any index outside the grid yields 0
module fk_angle_grid_lut
  import fk_pkg::*;
(
  input  grid_idx_t          idx,
  output logic signed [15:0] deg
);

  always_comb begin
    deg = DEG_0;
    case (idx)
      4'd0:    deg = DEG_0;
      4'd1:    deg = DEG_1;
      4'd2:    deg = DEG_2;
      4'd3:    deg = DEG_3;
      4'd4:    deg = DEG_4;
      4'd5:    deg = DEG_5;
      4'd6:    deg = DEG_6;
      4'd7:    deg = DEG_7;
      4'd8:    deg = DEG_8;
      default: deg = DEG_0;
    endcase
  end

endmodule

// File: rtl/fk_pose_sequencer.sv
// Command stage in front of the three-joint FK pipeline. Accepts a target
// pose (three grid indices) and walks every joint one grid step per update
// toward it, so FK only ever sees table angles. xy_valid marks the cycle in
// which FK's X/Y belong to a presented angle set.
//
// Handshake: a command is taken in any cycle where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE with rst low, so while busy the command
// inputs are ignored and may change freely.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_valid / cmd_ready    - command handshake
//   cmd_idx1..3              - target grid index per joint (legal 0..8)
//   theta1..3                - registered joint angles (degrees) to FK
//   angle_valid              - pulse in the first cycle of a new theta set
//   xy_valid                 - angle_valid delayed by FK_LATENCY
//   busy                     - sequencer not in IDLE
//   done                     - pulse with the xy_valid of the final step
//   cmd_err                  - pulse the cycle after a rejected command
module fk_pose_sequencer
  import fk_pkg::*;
#(
  parameter int DWELL      = 4,
  parameter int FK_LATENCY = FK_LATENCY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_idx1,
  input  logic [3:0]         cmd_idx2,
  input  logic [3:0]         cmd_idx3,
  output logic signed [15:0] theta1,
  output logic signed [15:0] theta2,
  output logic signed [15:0] theta3,
  output logic               angle_valid,
  output logic               xy_valid,
  output logic               busy,
  output logic               done,
  output logic               cmd_err
);

  state_e                  state_q, state_d;
  grid_idx_t [2:0]         cur_q, cur_d;
  grid_idx_t [2:0]         tgt_q, tgt_d;
  logic [7:0]              cnt_q, cnt_d;
  logic signed [15:0]      theta_q [3];
  logic signed [15:0]      theta_d [3];
  logic                    angle_valid_q, angle_valid_d;
  logic [FK_LATENCY-1:0]   sr_q, sr_d;
  logic                    cmd_err_q, cmd_err_d;
  logic                    younger_pending;
  logic signed [15:0]      lut_deg [3];

  // Angles are looked up from the next-state indices so theta is registered
  // in the same edge that commits the step.
  for (genvar j = 0; j < 3; j++) begin : g_lut
    fk_angle_grid_lut u_lut (
      .idx (cur_d[j]),
      .deg (lut_deg[j])
    );
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    tgt_d         = tgt_q;
    cnt_d         = cnt_q;
    angle_valid_d = 1'b0;
    cmd_err_d     = 1'b0;
    done          = 1'b0;
    cmd_ready     = (state_q == ST_IDLE) && !rst;

    // Pulses still travelling toward xy_valid behind the oldest one. With a
    // short DWELL, earlier steps' xy_valid can land while already in SETTLE,
    // so done waits for the pulse that has nothing younger behind it.
    younger_pending = angle_valid_q;
    for (int i = 0; i < FK_LATENCY - 1; i++) begin
      younger_pending = younger_pending | sr_q[i];
    end

    sr_d[0] = angle_valid_q;
    for (int i = 1; i < FK_LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if ((cmd_idx1 > 4'd8) || (cmd_idx2 > 4'd8) || (cmd_idx3 > 4'd8)) begin
            cmd_err_d = 1'b1;
          end else begin
            tgt_d   = {cmd_idx3, cmd_idx2, cmd_idx1};
            state_d = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        for (int j = 0; j < 3; j++) begin
          cur_d[j] = step_toward(cur_q[j], tgt_q[j]);
        end
        angle_valid_d = 1'b1;
        if (cur_d == tgt_q) begin
          state_d = ST_SETTLE;
        end else if (DWELL == 1) begin
          state_d = ST_MOVE;
        end else begin
          state_d = ST_DWELL;
          cnt_d   = 8'(DWELL - 1);
        end
      end
      ST_DWELL: begin
        if (cnt_q <= 8'd1) begin
          state_d = ST_MOVE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SETTLE: begin
        if (sr_q[FK_LATENCY-1] && !younger_pending) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int j = 0; j < 3; j++) begin
      theta_d[j] = lut_deg[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      tgt_q         <= '0;
      cnt_q         <= '0;
      angle_valid_q <= 1'b0;
      sr_q          <= '0;
      cmd_err_q     <= 1'b0;
      for (int j = 0; j < 3; j++) begin
        theta_q[j] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      tgt_q         <= tgt_d;
      cnt_q         <= cnt_d;
      angle_valid_q <= angle_valid_d;
      sr_q          <= sr_d;
      cmd_err_q     <= cmd_err_d;
      for (int j = 0; j < 3; j++) begin
        theta_q[j] <= theta_d[j];
      end
    end
  end

  assign theta1      = theta_q[0];
  assign theta2      = theta_q[1];
  assign theta3      = theta_q[2];
  assign angle_valid = angle_valid_q;
  assign xy_valid    = sr_q[FK_LATENCY-1];
  assign busy        = (state_q != ST_IDLE);
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_fk_pose_sequencer.sv
// Bench for fk_pose_sequencer: one instance with DWELL=4 and one with
// DWELL=1 share the command inputs; sel chooses which one is driven and
// monitored. A model walks the joints and queues the expected angle sets,
// xy_valid cycles, done cycles and cmd_err cycles; a negedge monitor pops
// and compares them as the DUT produces them.
module tb_fk_pose_sequencer;

  localparam int LAT = 3;

  typedef struct {
    int i1, i2, i3;
    int t1, t2, t3;
    int steps;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;
  logic       cmd_valid;
  logic [3:0] cmd_idx1, cmd_idx2, cmd_idx3;

  logic               cv4, rdy4, av4, xy4, busy4, done4, err4;
  logic signed [15:0] t1_4, t2_4, t3_4;
  logic               cv1, rdy1, av1, xy1, busy1, done1, err1;
  logic signed [15:0] t1_1, t2_1, t3_1;

  assign cv4 = cmd_valid & ~sel;
  assign cv1 = cmd_valid & sel;

  fk_pose_sequencer #(.DWELL(4), .FK_LATENCY(LAT)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cv4), .cmd_ready(rdy4),
    .cmd_idx1(cmd_idx1), .cmd_idx2(cmd_idx2), .cmd_idx3(cmd_idx3),
    .theta1(t1_4), .theta2(t2_4), .theta3(t3_4),
    .angle_valid(av4), .xy_valid(xy4), .busy(busy4), .done(done4), .cmd_err(err4)
  );

  fk_pose_sequencer #(.DWELL(1), .FK_LATENCY(LAT)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cv1), .cmd_ready(rdy1),
    .cmd_idx1(cmd_idx1), .cmd_idx2(cmd_idx2), .cmd_idx3(cmd_idx3),
    .theta1(t1_1), .theta2(t2_1), .theta3(t3_1),
    .angle_valid(av1), .xy_valid(xy1), .busy(busy1), .done(done1), .cmd_err(err1)
  );

  logic               m_rdy, m_av, m_xy, m_busy, m_done, m_err;
  logic signed [15:0] m_t1, m_t2, m_t3;
  assign m_rdy  = sel ? rdy1  : rdy4;
  assign m_av   = sel ? av1   : av4;
  assign m_xy   = sel ? xy1   : xy4;
  assign m_busy = sel ? busy1 : busy4;
  assign m_done = sel ? done1 : done4;
  assign m_err  = sel ? err1  : err4;
  assign m_t1   = sel ? t1_1  : t1_4;
  assign m_t2   = sel ? t2_1  : t2_4;
  assign m_t3   = sel ? t3_1  : t3_4;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [79:0] exp_q[$];
  int xy_q[$];
  int done_q[$];
  int err_q[$];
  int av_count = 0;
  int xy_count = 0;
  int done_count = 0;
  int ready_chk_cyc = -1;
  int grid [9] = '{0, 30, 45, 60, 90, 120, 135, 150, 180};
  int cur [2][3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [79:0] e;
    if (m_av) begin
      av_count++;
      if (exp_q.size() == 0) begin
        check("angle_valid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("angle_valid_cycle", cyc, int'(e[31:0]));
        check("theta1", int'(m_t1), int'($signed(e[79:64])));
        check("theta2", int'(m_t2), int'($signed(e[63:48])));
        check("theta3", int'(m_t3), int'($signed(e[47:32])));
      end
    end
    if (m_xy) begin
      xy_count++;
      if (xy_q.size() == 0) check("xy_valid_unexpected", 1, 0);
      else check("xy_valid_cycle", cyc, xy_q.pop_front());
    end
    if (m_done) begin
      done_count++;
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
      check("ready_low_at_done", int'(m_rdy), 0);
      ready_chk_cyc = cyc + 1;
    end
    if (cyc == ready_chk_cyc) check("ready_after_done", int'(m_rdy), 1);
    if (m_err) begin
      if (err_q.size() == 0) check("cmd_err_unexpected", 1, 0);
      else check("cmd_err_cycle", cyc, err_q.pop_front());
      check("busy_at_err", int'(m_busy), 0);
    end
    if (m_busy && m_rdy) check("ready_while_busy", 1, 0);
  end

  // driver: present a command, wait for the handshake, queue expectations
  task automatic send_cmd(input int a, input int b, input int c, output int t);
    int n, dw, s;
    int tg[3];
    logic [79:0] e;
    @(negedge clk);
    cmd_idx1 = 4'(a); cmd_idx2 = 4'(b); cmd_idx3 = 4'(c);
    cmd_valid = 1'b1;
    n = 0;
    while (!m_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (n >= 100) begin
      check("handshake_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    s  = sel ? 1 : 0;
    dw = sel ? 1 : 4;
    if (a > 8 || b > 8 || c > 8) begin
      err_q.push_back(t + 1);
    end else begin
      tg = '{a, b, c};
      n = 0;
      for (int j = 0; j < 3; j++) begin
        int d;
        d = (tg[j] > cur[s][j]) ? tg[j] - cur[s][j] : cur[s][j] - tg[j];
        if (d > n) n = d;
      end
      if (n == 0) n = 1;
      for (int k = 0; k < n; k++) begin
        int ck;
        for (int j = 0; j < 3; j++) begin
          if (cur[s][j] < tg[j]) cur[s][j]++;
          else if (cur[s][j] > tg[j]) cur[s][j]--;
        end
        ck = t + 2 + k * dw;
        e = {16'(grid[cur[s][0]]), 16'(grid[cur[s][1]]), 16'(grid[cur[s][2]]), 32'(ck)};
        exp_q.push_back(e);
        xy_q.push_back(ck + LAT);
        if (k == n - 1) done_q.push_back(ck + LAT);
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() + xy_q.size() + done_q.size() + err_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() + xy_q.size() + done_q.size() + err_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs [6];

  initial begin
    int t, xy0, done0;
    vecs[0] = '{2, 0, 1,  45,   0,  30, 2};
    vecs[1] = '{2, 0, 1,  45,   0,  30, 1};
    vecs[2] = '{0, 9, 0,  45,   0,  30, 0};
    vecs[3] = '{5, 3, 8, 120,  60, 180, 7};
    vecs[4] = '{0, 0, 0,   0,   0,   0, 8};
    vecs[5] = '{15, 0, 0,  0,   0,   0, 0};

    for (int s = 0; s < 2; s++) for (int j = 0; j < 3; j++) cur[s][j] = 0;
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0;
    cmd_idx1 = '0; cmd_idx2 = '0; cmd_idx3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_theta1", int'(m_t1), 0);
    check("reset_theta2", int'(m_t2), 0);
    check("reset_theta3", int'(m_t3), 0);
    check("reset_ready", int'(m_rdy), 1);
    check("reset_busy", int'(m_busy), 0);
    check("reset_pulses", int'({m_av, m_xy, m_done, m_err}), 0);
    check("reset_ready_dwell1", int'(rdy1), 1);

    // table-driven sequence on the DWELL=4 instance
    for (int i = 0; i < 6; i++) begin
      av_count = 0;
      send_cmd(vecs[i].i1, vecs[i].i2, vecs[i].i3, t);
      wait_drain();
      check("steps", av_count, vecs[i].steps);
      check("final_theta1", int'(m_t1), vecs[i].t1);
      check("final_theta2", int'(m_t2), vecs[i].t2);
      check("final_theta3", int'(m_t3), vecs[i].t3);
      check("idle_busy", int'(m_busy), 0);
    end

    // DWELL=1: back-to-back updates, done after the last xy_valid
    sel = 1'b1;
    av_count = 0;
    send_cmd(8, 8, 8, t);
    wait_drain();
    check("dwell1_steps", av_count, 8);
    check("dwell1_theta1", int'(m_t1), 180);
    check("dwell1_theta2", int'(m_t2), 180);
    check("dwell1_theta3", int'(m_t3), 180);

    // reset in the middle of a multi-step move
    sel = 1'b0;
    send_cmd(2, 0, 1, t);
    while (cyc < t + 4) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete(); xy_q.delete(); done_q.delete(); err_q.delete();
    for (int s = 0; s < 2; s++) for (int j = 0; j < 3; j++) cur[s][j] = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_cycle", cyc, t + 5);
    check("abort_theta1", int'(m_t1), 0);
    check("abort_theta3", int'(m_t3), 0);
    check("abort_busy", int'(m_busy), 0);
    xy0 = xy_count; done0 = done_count;
    repeat (10) @(negedge clk);
    check("abort_no_xy", xy_count - xy0, 0);
    check("abort_no_done", done_count - done0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fk_pose_sequencer.md
# fk_pose_sequencer

Upstream command stage for the three-joint forward-kinematics pipeline. Accepts target poses as joint-grid indices over a valid/ready handshake and walks each joint one grid step at a time toward its target, so every angle presented to FK is a supported table angle. Drives `theta1`/`theta2`/`theta3` into the FK block. Emits `xy_valid` aligned to FK's 3-cycle latency, so downstream logic knows exactly when FK's `X`/`Y` belong to a pose.

## Interface

Parameters:
- `DWELL`, default 4: cycles between consecutive angle updates. Legal range is 1..255.
- `FK_LATENCY`, default 3: cycles from a new theta being visible to the matching FK `X`/`Y` being visible.

Ports:
- `clk`, input, 1: the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `cmd_valid`, input, 1: target command present.
- `cmd_ready`, output, 1: high only when the block is in IDLE and `rst` is low.
- `cmd_idx1`, `cmd_idx2`, `cmd_idx3`, input, 4 each: target grid index per joint. Legal range is 0..8.
- `theta1`, `theta2`, `theta3`, output, 16 signed each: current joint angle in degrees, registered. Connects to the FK inputs.
- `angle_valid`, output, 1: one-cycle pulse in the first cycle a new theta set is visible.
- `xy_valid`, output, 1: `angle_valid` delayed by `FK_LATENCY` cycles. Marks valid FK `X`/`Y`.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse coincident with the `xy_valid` of the final step.
- `cmd_err`, output, 1: one-cycle pulse after a rejected command.

## Operation

- Angle grid, index 0..8 maps to degrees 0, 30, 45, 60, 90, 120, 135, 150, 180.
- Each joint holds a 4-bit current index. The corresponding `theta` output is the grid degree for that index.
- States are IDLE, MOVE, DWELL, SETTLE.
- IDLE:
  - A handshake is `cmd_valid && cmd_ready`.
  - If any `cmd_idx` is greater than 8: pulse `cmd_err` next cycle, stay in IDLE, no other change.
  - Otherwise latch the three targets and go to MOVE.
- MOVE (always exactly 1 cycle):
  - Each joint steps its current index by sign(target − current): +1, −1 or 0.
  - Register the new theta values and pulse `angle_valid` in the next cycle.
  - If all post-step indices equal their targets, go to SETTLE.
  - Otherwise, if `DWELL` is 1, go back to MOVE; if not, go to DWELL.
- A command equal to the current pose still passes through MOVE once. It produces one `angle_valid` with unchanged angles, then `done`.
- DWELL: count `DWELL`−1 cycles, then return to MOVE. Consecutive `angle_valid` pulses are therefore exactly `DWELL` cycles apart.
- SETTLE: wait until the final step's `xy_valid` is asserted. Pulse `done` in that same cycle, then return to IDLE.
- `xy_valid` comes from an `FK_LATENCY`-deep shift register fed by `angle_valid`. It runs independently of the state machine.
- The joints move independently. The number of steps equals the largest per-joint index distance; joints that reach their target early hold.
- The FK block sums the angles; this block does not check the sums. Out-of-table sums are FK's concern.

## Timing

- Reset state, taking effect in the cycle after `rst` is sampled high:
  - State is IDLE, all indices and targets are 0, all `theta` are 0.
  - `angle_valid`, `xy_valid`, `done` and `cmd_err` are 0.
  - The shift register is flushed and `busy` is 0.
  - `cmd_ready` is 0 while `rst` is high and 1 in the first cycle after reset.
- Handshake in cycle t:
  - First MOVE is in t+1, and the first `angle_valid` is in t+2.
  - Step k, counting from 0, has `angle_valid` at t+2+k·`DWELL`.
- Final `angle_valid` at cycle a:
  - `xy_valid` and `done` are at a+`FK_LATENCY`.
  - `cmd_ready` returns high at a+`FK_LATENCY`+1.
- While `busy`, `cmd_ready` is low. `cmd_valid` is ignored and `cmd_idx` may change freely.
- Reset mid-operation aborts immediately. No later `angle_valid`, `xy_valid` or `done` pulse may appear.
- `cmd_err` and an accept can never occur in the same cycle.

## Structure

- Shared package `fk_pkg` holds:
  - `GRID_N` = 9.
  - The angle-grid degree constants.
  - `FK_LATENCY_DEFAULT` = 3.
  - A state enum typedef.
  - A 4-bit grid-index typedef.
- Sub-module `fk_angle_grid_lut`: combinational index-to-degree lookup. Instantiated three times, once per joint. Any out-of-range index returns 0.

## Test plan

- Reset, then release → all `theta` = 0, `cmd_ready` = 1, `busy` = 0, no pulses.
- `DWELL`=4, command (2,0,1) accepted at t:
  - `angle_valid` at t+2 with `theta` = (30,0,30), and at t+6 with (45,0,30).
  - `xy_valid` at t+5 and t+9; `done` at t+9; `cmd_ready` high at t+10.
- Command with `cmd_idx2` = 9 → `cmd_err` at t+1, `busy` stays 0, `theta` unchanged.
- Command equal to the current pose → single `angle_valid` at t+2; `xy_valid` and `done` at t+5.
- `DWELL`=1, command (8,8,8) from reset:
  - `angle_valid` on every cycle from t+2 through t+9, ending with `theta` = (180,180,180).
  - `done` at t+12.
- `rst` asserted at t+4 during a multi-step move:
  - `theta` = 0 and `busy` = 0 at t+5.
  - No `xy_valid` or `done` pulse in the following 10 cycles.
